apb_timer_master: RTL
=====================

// Module: apb_timer_master
// PURPOSE
//  APB initiator driving the timer register file (TCR..THCSR) from a simple valid/ready command port.
//  Converts one command into one APB transfer (SETUP -> ACCESS), waits on pready, returns rdata/error.
//  Sits between the test/CPU-side sequencer and the timer slave. Single outstanding transfer, no pipelining.
// PARAMETERS
//  ADDR_SIZE    12  APB address width
//  DATA_SIZE    32  APB data width
//  PSTRB_SIZE   4   byte strobes (DATA_SIZE/8)
//  TIMEOUT_CYC  16  max ACCESS cycles waiting for pready; 0 = no timeout; counter width $clog2(TIMEOUT_CYC+1)
// PORTS
//  sys_clk      in   1           system clock, all logic on rising edge
//  sys_rst      in   1           reset, synchronous, active-high
//  cmd_valid    in   1           command request
//  cmd_ready    out  1           command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1           1 = write, 0 = read
//  cmd_addr     in   ADDR_SIZE   byte address
//  cmd_wdata    in   DATA_SIZE   write data
//  cmd_strb     in   PSTRB_SIZE  write byte strobes
//  rsp_valid    out  1           response available, held until rsp_ready
//  rsp_ready    in   1           response consumed
//  rsp_rdata    out  DATA_SIZE   read data (0 for writes and errors)
//  rsp_err      out  1           pslverr, misaligned, or timeout
//  rsp_timeout  out  1           error cause was timeout
//  psel/penable/pwrite out 1     APB control
//  paddr        out  ADDR_SIZE   APB address
//  pwdata       out  DATA_SIZE   APB write data
//  pstrb        out  PSTRB_SIZE  APB strobes (forced 0 on reads)
//  pready/pslverr in 1           APB slave response
//  prdata       in   DATA_SIZE   APB read data
// BEHAVIOUR
//  All outputs registered. Reset: state IDLE, psel=penable=pwrite=0, paddr/pwdata/pstrb=0,
//   rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, timeout counter 0. Reset mid-transfer aborts; no response.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE: cmd_ready=1 (combinational from state==IDLE). On accept at edge N, capture all cmd fields.
//   cmd_addr[1:0]!=0: no bus cycle; -> RESP, rsp_err=1, rsp_timeout=0, rsp_valid=1 from N+1.
//  SETUP (N+1): psel=1, penable=0, paddr/pwrite/pwdata/pstrb valid and stable until transfer ends.
//  ACCESS (from N+2): psel=1, penable=1. pready=1 at an edge: sample prdata (reads only) and pslverr,
//   drop psel/penable, -> RESP. Min command-to-rsp_valid latency = 3 cycles.
//  Timeout: counter increments each ACCESS cycle with pready=0; reaching TIMEOUT_CYC -> drop psel/penable,
//   -> RESP, rsp_err=1, rsp_timeout=1, rsp_rdata=0. pready on the same edge as expiry wins (normal completion).
//  RESP: rsp_valid=1, fields stable; rsp_valid & rsp_ready -> IDLE, rsp_valid=0 next cycle. cmd_ready=0.
//   Earliest next accept is the cycle after the RESP handshake (no back-to-back SETUP).
//  Reads: pstrb=0, pwdata=0. rsp_rdata=0 on writes or when rsp_err=1.
//  cmd_valid ignored outside IDLE; cmd fields may change freely after acceptance.
// STRUCTURE
//  Shared package timer_apb_pkg: state enum (IDLE,SETUP,ACCESS,RESP); register address constants
//   TCR=0x00 TDR0=0x04 TDR1=0x08 TCMP0=0x0C TCMP1=0x10 TIER=0x14 TISR=0x18 THCSR=0x1C.
//  Flat module; timeout counter is too small to justify a sub-module.
// TESTING
//  1 Write TCR=0x0000_0103, strb=F, pready=1 in first ACCESS -> SETUP@N+1, ACCESS@N+2, rsp_valid@N+3, rsp_err=0.
//  2 Read TCMP0 after reset, pready after 3 wait cycles, prdata=0xFFFF_FFFF -> rsp_rdata=0xFFFF_FFFF, pstrb=0, ACCESS 4 cycles.
//  3 TIMEOUT_CYC=16, pready held 0 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//  4 Write TCR div_val=0xA with pslverr=1 -> rsp_err=1, rsp_timeout=0; rsp held 5 cycles while rsp_ready=0.
//  5 cmd_addr=0x006 -> no psel assertion, rsp_err=1 one cycle after accept; cmd_ready=0 until rsp handshake.
//  6 sys_rst asserted in ACCESS -> next edge psel=penable=0, rsp_valid=0, cmd_ready=1; new command completes normally.

Source files
------------

// File: rtl/timer_apb_pkg.sv
// rtl/timer_apb_pkg.sv - shared state encoding and timer register map for the APB timer master
package timer_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [11:0] TCR   = 12'h000;
  localparam logic [11:0] TDR0  = 12'h004;
  localparam logic [11:0] TDR1  = 12'h008;
  localparam logic [11:0] TCMP0 = 12'h00C;
  localparam logic [11:0] TCMP1 = 12'h010;
  localparam logic [11:0] TIER  = 12'h014;
  localparam logic [11:0] TISR  = 12'h018;
  localparam logic [11:0] THCSR = 12'h01C;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/apb_timer_master.sv
// rtl/apb_timer_master.sv - one command in, one APB transfer out, one response back
module apb_timer_master
  import timer_apb_pkg::*;
#(
  parameter int ADDR_SIZE   = 12,
  parameter int DATA_SIZE   = 32,
  parameter int PSTRB_SIZE  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_SIZE-1:0]  cmd_addr,
  input  logic [DATA_SIZE-1:0]  cmd_wdata,
  input  logic [PSTRB_SIZE-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_SIZE-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_SIZE-1:0]  paddr,
  output logic [DATA_SIZE-1:0]  pwdata,
  output logic [PSTRB_SIZE-1:0] pstrb,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_SIZE-1:0]  prdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_misaligned;
  logic             w_done;
  logic             w_expire;

  assign cmd_ready    = (r_state == IDLE);
  assign w_accept     = cmd_valid && (r_state == IDLE);
  assign w_misaligned = !is_word_aligned(cmd_addr[1:0]);
  assign w_done       = (r_state == ACCESS) && pready;
  // pready on the expiry edge is a normal completion, so expiry requires pready low
  assign w_expire     = (r_state == ACCESS) && !pready && (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_misaligned ? RESP : SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_done || w_expire) w_state_nxt = RESP;
      RESP:    if (rsp_valid && rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt       <= '0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            if (w_misaligned) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= cmd_write;
              paddr   <= cmd_addr;
              pwdata  <= cmd_write ? cmd_wdata : '0;
              pstrb   <= cmd_write ? cmd_strb : '0;
              rsp_err <= 1'b0;
            end
          end
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (w_done) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
          end else if (w_expire) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
